// File: rtl/parallel_descrambler.sv
`default_nettype none
// ============================================================================
// parallel_descrambler : WIDTH-bit-per-beat x^7+x^4+1 descrambler, seed taken
//                        from the SERVICE field (SYNC_EN=1) or preset (SYNC_EN=0)
// Revision 1.0
// ============================================================================
module parallel_descrambler #(
   parameter int         WIDTH   = 1,
   parameter bit         SYNC_EN = 1'b1,
   parameter logic [6:0] SEED    = 7'b1111111
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             InValid,
   input  logic [WIDTH-1:0] Input,
   input  logic             FrameStart,
   input  logic             Bypass,
   output logic             OutValid,
   output logic [WIDTH-1:0] Output,
   output logic [6:0]       SeedOut,
   output logic             SeedValid,
   output logic             SeedError
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SYNC = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   localparam logic [6:0] c_lfsr_init = 7'b1111111;
   localparam logic [4:0] c_cnt_max   = 5'd16;

   state_t             r_state;
   logic [6:0]         r_lfsr;
   logic [4:0]         r_cnt;
   logic               r_out_valid;
   logic [WIDTH-1:0]   r_data;
   logic [6:0]         r_seed_out;
   logic               r_seed_valid;
   logic               r_seed_error;

   state_t             w_state;
   logic [6:0]         w_lfsr;
   logic [4:0]         w_cnt;
   logic               w_err;
   logic [WIDTH-1:0]   w_data;
   logic               w_seed_hit;
   logic [6:0]         w_seed;
   logic               w_f;

   // Whole beat is walked bit by bit; the state may change from SYNC to RUN
   // part-way through, so later bits of the same beat are descrambled.
   always_comb begin
      w_state    = r_state;
      w_lfsr     = r_lfsr;
      w_cnt      = r_cnt;
      w_err      = r_seed_error;
      w_data     = '0;
      w_seed_hit = 1'b0;
      w_seed     = r_seed_out;
      w_f        = 1'b0;
      if (FrameStart) begin
         w_cnt = '0;
         w_err = 1'b0;
         if (SYNC_EN) begin
            w_state = ST_SYNC;
         end else begin
            w_state = ST_RUN;
            w_lfsr  = SEED;
         end
      end
      for (int i = 0; i < WIDTH; i++) begin
         case (w_state)
            ST_SYNC: begin
               w_lfsr    = {w_lfsr[5:0], Input[i]};
               w_data[i] = 1'b0;
               w_cnt     = (w_cnt == c_cnt_max) ? c_cnt_max : w_cnt + 5'd1;
               if (w_cnt == 5'd7) begin
                  w_state    = ST_RUN;
                  w_seed_hit = 1'b1;
                  w_seed     = w_lfsr;
               end
            end
            ST_RUN: begin
               w_f       = w_lfsr[6] ^ w_lfsr[3];
               w_data[i] = Input[i] ^ w_f;
               if (w_data[i] && (w_cnt >= 5'd7) && (w_cnt <= 5'd15)) begin
                  w_err = 1'b1;
               end
               w_lfsr = {w_lfsr[5:0], w_f};
               w_cnt  = (w_cnt == c_cnt_max) ? c_cnt_max : w_cnt + 5'd1;
            end
            default: begin
               w_data[i] = Input[i];
            end
         endcase
      end
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         r_state      <= ST_IDLE;
         r_lfsr       <= c_lfsr_init;
         r_cnt        <= '0;
         r_out_valid  <= 1'b0;
         r_data       <= '0;
         r_seed_out   <= '0;
         r_seed_valid <= 1'b0;
         r_seed_error <= 1'b0;
      end else begin
         r_seed_valid <= 1'b0;
         r_out_valid  <= InValid;
         if (InValid && Bypass) begin
            r_data <= Input;
         end else if (InValid) begin
            r_state      <= w_state;
            r_lfsr       <= w_lfsr;
            r_cnt        <= w_cnt;
            r_data       <= w_data;
            r_seed_error <= w_err;
            if (w_seed_hit) begin
               r_seed_out   <= w_seed;
               r_seed_valid <= 1'b1;
            end
         end
      end
   end

   assign OutValid  = r_out_valid;
   assign Output    = r_data;
   assign SeedOut   = r_seed_out;
   assign SeedValid = r_seed_valid;
   assign SeedError = r_seed_error;

endmodule
`default_nettype wire

// File: tb/tb_parallel_descrambler.sv
`default_nettype none
// ============================================================================
// tb_parallel_descrambler : directed checks over WIDTH 1/2/4/8 and SYNC_EN 0/1
// Revision 1.0
// ============================================================================
module tb_parallel_descrambler;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       vld   = 1'b0;
   logic       fs    = 1'b0;
   logic       byp   = 1'b0;
   logic [7:0] din   = 8'h00;
   int         sel   = 0;

   int n_checks = 0;
   int n_errors = 0;

   wire       ov0, ov1, ov2, ov3, ov4;
   wire [0:0] od0;
   wire [7:0] od1;
   wire [3:0] od2;
   wire [1:0] od3;
   wire [7:0] od4;
   wire [6:0] so0, so1, so2, so3, so4;
   wire       sv0, sv1, sv2, sv3, sv4;
   wire       se0, se1, se2, se3, se4;

   always #5 clk = ~clk;

   parallel_descrambler #(.WIDTH(1), .SYNC_EN(1'b1)) u_w1 (
      .Clock(clk), .Reset(rst_n), .InValid(vld && sel == 0), .Input(din[0:0]),
      .FrameStart(fs), .Bypass(byp), .OutValid(ov0), .Output(od0),
      .SeedOut(so0), .SeedValid(sv0), .SeedError(se0));
   parallel_descrambler #(.WIDTH(8), .SYNC_EN(1'b1)) u_w8 (
      .Clock(clk), .Reset(rst_n), .InValid(vld && sel == 1), .Input(din),
      .FrameStart(fs), .Bypass(byp), .OutValid(ov1), .Output(od1),
      .SeedOut(so1), .SeedValid(sv1), .SeedError(se1));
   parallel_descrambler #(.WIDTH(4), .SYNC_EN(1'b1)) u_w4 (
      .Clock(clk), .Reset(rst_n), .InValid(vld && sel == 2), .Input(din[3:0]),
      .FrameStart(fs), .Bypass(byp), .OutValid(ov2), .Output(od2),
      .SeedOut(so2), .SeedValid(sv2), .SeedError(se2));
   parallel_descrambler #(.WIDTH(2), .SYNC_EN(1'b1)) u_w2 (
      .Clock(clk), .Reset(rst_n), .InValid(vld && sel == 3), .Input(din[1:0]),
      .FrameStart(fs), .Bypass(byp), .OutValid(ov3), .Output(od3),
      .SeedOut(so3), .SeedValid(sv3), .SeedError(se3));
   parallel_descrambler #(.WIDTH(8), .SYNC_EN(1'b0), .SEED(7'b1011101)) u_s0 (
      .Clock(clk), .Reset(rst_n), .InValid(vld && sel == 4), .Input(din),
      .FrameStart(fs), .Bypass(byp), .OutValid(ov4), .Output(od4),
      .SeedOut(so4), .SeedValid(sv4), .SeedError(se4));

   logic       c_ov, c_sv, c_se;
   logic [7:0] c_od;
   logic [6:0] c_so;

   always_comb begin
      c_ov = 1'b0; c_sv = 1'b0; c_se = 1'b0; c_od = 8'h00; c_so = 7'h00;
      case (sel)
         0: begin c_ov = ov0; c_od = {7'd0, od0}; c_so = so0; c_sv = sv0; c_se = se0; end
         1: begin c_ov = ov1; c_od = od1;         c_so = so1; c_sv = sv1; c_se = se1; end
         2: begin c_ov = ov2; c_od = {4'd0, od2}; c_so = so2; c_sv = sv2; c_se = se2; end
         3: begin c_ov = ov3; c_od = {6'd0, od3}; c_so = so3; c_sv = sv3; c_se = se3; end
         default: begin c_ov = ov4; c_od = od4;   c_so = so4; c_sv = sv4; c_se = se4; end
      endcase
   end

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One beat to instance s; outputs are sampled 1 time unit after the edge.
   task automatic beat(input int s, input logic v, input logic [7:0] d,
                       input logic f, input logic b);
      sel = s; vld = v; din = d; fs = f; byp = b;
      @(posedge clk);
      #1;
   endtask

   // All-ones-seed sequence 0000111011110010, bit 0 first.
   logic [15:0] seq     = 16'h4F70;
   logic [1:0]  pairs [8] = '{2'd0, 2'd0, 2'd3, 2'd1, 2'd3, 2'd3, 2'd0, 2'd1};
   logic [7:0]  plain [6] = '{8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
   logic [7:0]  scr   [6];
   logic        x     [55];

   initial begin
      // Additive scrambler for SEED=1011101 as a bit recurrence x[n]=x[n-7]^x[n-4].
      for (int k = 0; k < 7; k++) x[k] = SEED_BITS(k);
      for (int n = 7; n < 55; n++) x[n] = x[n-7] ^ x[n-4];
      for (int j = 0; j < 6; j++)
         for (int b = 0; b < 8; b++) scr[j][b] = plain[j][b] ^ x[j*8 + b + 7];

      // Reset state
      beat(0, 1'b1, 8'h01, 1'b1, 1'b0);
      beat(0, 1'b1, 8'h01, 1'b1, 1'b0);
      check("rst ov", c_ov, 8'd0);
      check("rst od", c_od, 8'd0);
      check("rst so", c_so, 7'd0);
      check("rst sv", c_sv, 8'd0);
      check("rst se", c_se, 8'd0);
      rst_n = 1'b1;

      // WIDTH=1 sync from the all-ones sequence
      for (int i = 0; i < 16; i++) begin
         beat(0, 1'b1, {7'd0, seq[i]}, i == 0, 1'b0);
         check($sformatf("w1 ov%0d", i), c_ov, 8'd1);
         check($sformatf("w1 od%0d", i), c_od, 8'd0);
         check($sformatf("w1 sv%0d", i), c_sv, {7'd0, i == 6});
         if (i == 6) check("w1 so", c_so, 7'h07);
      end
      check("w1 se", c_se, 8'd0);
      beat(0, 1'b0, 8'h00, 1'b0, 1'b0);

      // WIDTH=8: idle passthrough, 2-beat sync, gap hold, bypass, LFSR hold
      beat(1, 1'b1, 8'hA5, 1'b0, 1'b0);
      check("w8 idle od", c_od, 8'hA5);
      check("w8 idle ov", c_ov, 8'd1);
      beat(1, 1'b1, seq[7:0], 1'b1, 1'b0);
      check("w8 od0", c_od, 8'h00);
      check("w8 ov0", c_ov, 8'd1);
      check("w8 sv0", c_sv, 8'd1);
      check("w8 so", c_so, 7'h07);
      beat(1, 1'b1, seq[15:8], 1'b0, 1'b0);
      check("w8 od1", c_od, 8'h00);
      check("w8 sv1", c_sv, 8'd0);
      check("w8 se", c_se, 8'd0);
      beat(1, 1'b0, 8'hFF, 1'b0, 1'b0);
      check("w8 gap ov", c_ov, 8'd0);
      check("w8 gap od", c_od, 8'h00);
      beat(1, 1'b1, 8'h3C, 1'b1, 1'b1);
      check("w8 byp od", c_od, 8'h3C);
      check("w8 byp ov", c_ov, 8'd1);
      beat(1, 1'b1, 8'h00, 1'b0, 1'b0);
      check("w8 after byp od", c_od, 8'h93);
      beat(1, 1'b0, 8'h00, 1'b0, 1'b0);

      // WIDTH=4 with SERVICE bit 9 flipped, then restart by FrameStart
      beat(2, 1'b1, 8'h0, 1'b1, 1'b0);
      check("w4 od0", c_od, 8'h0);
      check("w4 sv0", c_sv, 8'd0);
      beat(2, 1'b1, 8'h7, 1'b0, 1'b0);
      check("w4 od1", c_od, 8'h0);
      check("w4 sv1", c_sv, 8'd1);
      check("w4 so", c_so, 7'h07);
      check("w4 se1", c_se, 8'd0);
      beat(2, 1'b1, 8'hD, 1'b0, 1'b0);
      check("w4 od2", c_od, 8'h2);
      check("w4 se2", c_se, 8'd1);
      beat(2, 1'b0, 8'h0, 1'b0, 1'b0);
      check("w4 gap ov", c_ov, 8'd0);
      check("w4 gap od", c_od, 8'h2);
      check("w4 gap se", c_se, 8'd1);
      beat(2, 1'b1, 8'h4, 1'b0, 1'b0);
      check("w4 od3", c_od, 8'h0);
      check("w4 se3", c_se, 8'd1);
      beat(2, 1'b1, 8'h0, 1'b1, 1'b0);
      check("w4 restart se", c_se, 8'd0);
      beat(2, 1'b1, 8'h7, 1'b0, 1'b0);
      check("w4 restart sv", c_sv, 8'd1);
      beat(2, 1'b1, 8'hD, 1'b0, 1'b0);
      check("w4 restart se2", c_se, 8'd1);

      // Reset mid-RUN, idle beat, then a clean frame
      rst_n = 1'b0;
      beat(2, 1'b1, 8'h4, 1'b1, 1'b0);
      check("mid rst ov", c_ov, 8'd0);
      check("mid rst od", c_od, 8'd0);
      check("mid rst so", c_so, 7'd0);
      check("mid rst sv", c_sv, 8'd0);
      check("mid rst se", c_se, 8'd0);
      rst_n = 1'b1;
      beat(2, 1'b1, 8'h9, 1'b0, 1'b0);
      check("post rst idle od", c_od, 8'h9);
      beat(2, 1'b1, 8'h0, 1'b1, 1'b0);
      beat(2, 1'b1, 8'h7, 1'b0, 1'b0);
      check("post rst sv", c_sv, 8'd1);
      check("post rst so", c_so, 7'h07);
      beat(2, 1'b1, 8'hF, 1'b0, 1'b0);
      check("post rst od2", c_od, 8'h0);
      beat(2, 1'b1, 8'h4, 1'b0, 1'b0);
      check("post rst od3", c_od, 8'h0);
      check("post rst se", c_se, 8'd0);
      beat(2, 1'b0, 8'h0, 1'b0, 1'b0);

      // WIDTH=2 with InValid gaps during SYNC
      for (int i = 0; i < 8; i++) begin
         beat(3, 1'b1, {6'd0, pairs[i]}, i == 0, 1'b0);
         check($sformatf("w2 ov%0d", i), c_ov, 8'd1);
         check($sformatf("w2 od%0d", i), c_od, 8'd0);
         check($sformatf("w2 sv%0d", i), c_sv, {7'd0, i == 3});
         if (i < 2) begin
            beat(3, 1'b0, 8'h3, 1'b0, 1'b0);
            check($sformatf("w2 gap ov%0d", i), c_ov, 8'd0);
         end
      end
      check("w2 so", c_so, 7'h07);
      check("w2 se", c_se, 8'd0);
      beat(3, 1'b0, 8'h0, 1'b0, 1'b0);

      // SYNC_EN=0 with preset SEED
      for (int j = 0; j < 6; j++) begin
         beat(4, 1'b1, scr[j], j == 0, 1'b0);
         check($sformatf("s0 od%0d", j), c_od, plain[j]);
      end
      check("s0 sv", c_sv, 8'd0);
      beat(4, 1'b0, 8'h00, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   function automatic logic SEED_BITS(input int k);
      logic [6:0] s;
      s = 7'b1011101;
      return s[6-k];
   endfunction

endmodule
`default_nettype wire
